cmd_frame_sender: RTL and testbench



---
 rtl/cmd_frame_sender_pkg.sv | 27 ++
 rtl/cmd_frame_sender_hex.sv | 16 +
 rtl/cmd_frame_sender.sv | 133 +++++++++++++
 tb/tb_cmd_frame_sender.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_sender_pkg.sv
// Shared types and constants for the command frame sender.
// CMD_FRAME_CRLF_EN appends CR/LF after the trailer byte.
package cmd_frame_sender_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StGuard,
    StWaitFree,
    StDone
  } state_e;

  localparam int unsigned DigitsDefault  = 8;
  localparam logic [7:0]  HdrCharDefault = 8'h68;
  localparam logic [7:0]  TrlCharDefault = 8'h67;
  localparam logic [7:0]  CrChar         = 8'h0D;
  localparam logic [7:0]  LfChar         = 8'h0A;

`ifdef CMD_FRAME_CRLF_EN
  localparam int unsigned FrameOverhead = 4;
`else
  localparam int unsigned FrameOverhead = 2;
`endif

  localparam int unsigned FrameLenDefault = DigitsDefault + FrameOverhead;

endpackage

// File: rtl/cmd_frame_sender_hex.sv
// Combinational nibble to uppercase ASCII hex encoder.
module hex_nibble_to_ascii (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii_o = 8'h30 + {4'h0, nibble_i};
    end else begin
      // 'A' - 10 == 8'h37
      ascii_o = 8'h37 + {4'h0, nibble_i};
    end
  end

endmodule

// File: rtl/cmd_frame_sender.sv
// Serialises a value into 'h' + hex digits + 'g' over a byte UART handshake.
// Optional CMD_FRAME_CRLF_EN appends 8'h0D, 8'h0A before done.
module cmd_frame_sender
  import cmd_frame_sender_pkg::*;
#(
  parameter int unsigned DIGITS   = DigitsDefault,
  parameter logic [7:0]  HDR_CHAR = HdrCharDefault,
  parameter logic [7:0]  TRL_CHAR = TrlCharDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   value,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            tx_data,
  output logic                  new_tx_data,
  input  logic                  tx_busy
);

  localparam int unsigned FrameLen = DIGITS + FrameOverhead;
  localparam int unsigned IdxW     = $clog2(FrameLen + 1);
  localparam int unsigned ValW     = 4 * DIGITS;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [ValW-1:0] shreg_q, shreg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            new_q, new_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic [7:0]      hex_char;
  logic [7:0]      cur_byte;
  logic            is_digit;
  logic            last_sent;

  hex_nibble_to_ascii u_hex (
    .nibble_i (shreg_q[ValW-1 -: 4]),
    .ascii_o  (hex_char)
  );

  assign is_digit  = (idx_q != '0) && (idx_q <= IdxW'(DIGITS));
  assign last_sent = (idx_q == IdxW'(FrameLen));

  always_comb begin
    cur_byte = TRL_CHAR;
    if (idx_q == '0) begin
      cur_byte = HDR_CHAR;
    end else if (is_digit) begin
      cur_byte = hex_char;
    end else if (idx_q == IdxW'(DIGITS + 1)) begin
      cur_byte = TRL_CHAR;
`ifdef CMD_FRAME_CRLF_EN
    end else if (idx_q == IdxW'(DIGITS + 2)) begin
      cur_byte = CrChar;
    end else begin
      cur_byte = LfChar;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      shreg_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      new_q     <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      new_q     <= new_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (start) state_d = StSend;
      StSend:     if (!tx_busy) state_d = StGuard;
      // Covers the transmitter's one-cycle tx_busy rise latency
      StGuard:    state_d = StWaitFree;
      StWaitFree: if (!tx_busy) state_d = last_sent ? StDone : StSend;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    new_d     = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d = value;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          tx_data_d = cur_byte;
          new_d     = 1'b1;
          idx_d     = idx_q + IdxW'(1);
          if (is_digit) shreg_d = shreg_q << 4;
        end
      end
      StGuard: ;
      StWaitFree: begin
        if (!tx_busy && last_sent) done_d = 1'b1;
      end
      StDone: busy_d = 1'b0;
      default: ;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign new_tx_data = new_q;
  assign tx_data     = tx_data_q;

endmodule

// File: tb/tb_cmd_frame_sender.sv
// Randomised bench for cmd_frame_sender with a byte-queue frame model and UART busy model.
module tb_cmd_frame_sender;

  localparam int Digits = 8;
`ifdef CMD_FRAME_CRLF_EN
  localparam int FrameLen = Digits + 4;
`else
  localparam int FrameLen = Digits + 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = 32'h0;
  logic        busy, done, new_tx_data;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_busy_drv = 1'b0;
  logic        uart_busy = 1'b0;
  int          uart_en = 0;
  int          uart_len = 0;
  int          uart_cnt = 0;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  logic        busy_at_edge = 1'b0;
  logic        prev_new = 1'b0;
  int          viol = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          strobe_cyc[$];

  assign tx_busy = tx_busy_drv | uart_busy;

  always #5 clk = ~clk;

  cmd_frame_sender dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .value       (value),
    .busy        (busy),
    .done        (done),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy)
  );

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= tx_busy;
  end

  // Monitor plus UART model: tx_busy rises the cycle after a strobe, stays high uart_len cycles
  always @(negedge clk) begin
    if (new_tx_data) begin
      rx_q.push_back(tx_data);
      strobe_cyc.push_back(cyc);
      if (prev_new) viol++;
      if (busy_at_edge) viol++;
    end
    prev_new = new_tx_data;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (uart_en != 0) begin
      if (new_tx_data) uart_cnt = uart_len + 1;
      else if (uart_cnt > 0) uart_cnt--;
    end else begin
      uart_cnt = 0;
    end
    uart_busy = (uart_cnt > 0) && (uart_cnt <= uart_len);
  end

  function automatic void model_frame(input logic [31:0] v);
    logic [3:0] nib;
    exp_q.delete();
    exp_q.push_back(8'h68);
    for (int i = 0; i < Digits; i++) begin
      nib = v[4*(Digits-1-i) +: 4];
      if (nib < 10) exp_q.push_back(8'h30 + {4'h0, nib});
      else          exp_q.push_back(8'h41 + {4'h0, nib} - 8'd10);
    end
    exp_q.push_back(8'h67);
`ifdef CMD_FRAME_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  function automatic int frame_errs();
    int e = 0;
    if (rx_q.size() != exp_q.size()) e++;
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
      if (rx_q[i] !== exp_q[i]) e++;
    return e;
  endfunction

  function automatic int bad_gaps(input int want);
    int e = 0;
    for (int i = 1; i < strobe_cyc.size(); i++)
      if (strobe_cyc[i] - strobe_cyc[i-1] != want) e++;
    return e;
  endfunction

  task automatic clear_mon();
    @(negedge clk);
    rx_q.delete();
    strobe_cyc.delete();
    viol     = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] v, output int acc_cyc);
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    acc_cyc = cyc;
    value   = $urandom();
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++;
    if (new_tx_data !== 1'b0) begin
      tests_failed++; $display("FAIL reset_new: got %b want 0", new_tx_data);
    end
    tests_run++;
    if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_txdata: got %h want 00", tx_data); end
    rst = 1'b0;
  endtask

  task automatic test_fixed_frame(input logic [31:0] v);
    int acc;
    bit ok;
    uart_en = 0;
    clear_mon();
    model_frame(v);
    pulse_start(v, acc);
    wait_done(200, ok);
    repeat (3) @(negedge clk);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL fixed_%h_timeout: no done within 200 cycles", v); end
    tests_run++;
    if (frame_errs() !== 0) begin
      tests_failed++;
      $display("FAIL fixed_%h_frame: %0d byte errors, got %0d bytes want %0d", v, frame_errs(),
               rx_q.size(), exp_q.size());
    end
    tests_run++;
    if (strobe_cyc.size() == 0 || strobe_cyc[0] !== acc + 1) begin
      tests_failed++;
      $display("FAIL fixed_%h_latency: first strobe cycle %0d want %0d", v,
               (strobe_cyc.size() == 0) ? -1 : strobe_cyc[0], acc + 1);
    end
    tests_run++;
    if (bad_gaps(3) !== 0) begin
      tests_failed++; $display("FAIL fixed_%h_spacing: %0d gaps not 3 cycles", v, bad_gaps(3));
    end
    tests_run++;
    if (strobe_cyc.size() == 0 || done_cyc !== strobe_cyc[strobe_cyc.size()-1] + 2) begin
      tests_failed++; $display("FAIL fixed_%h_done_time: done cycle %0d, want last strobe + 2", v, done_cyc);
    end
    tests_run++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL fixed_%h_end: done_cnt %0d busy %b want 1 and 0", v, done_cnt, busy);
    end
    tests_run++;
    if (viol !== 0) begin tests_failed++; $display("FAIL fixed_%h_protocol: %0d violations want 0", v, viol); end
  endtask

  task automatic test_uart_model(input int len, input int frames);
    int acc;
    bit ok;
    logic [31:0] v;
    uart_en  = 1;
    uart_len = len;
    for (int f = 0; f < frames; f++) begin
      v = $urandom();
      clear_mon();
      model_frame(v);
      pulse_start(v, acc);
      wait_done(FrameLen * (len + 6) + 50, ok);
      repeat (2) @(negedge clk);
      tests_run++;
      if (!ok || frame_errs() !== 0 || done_cnt !== 1) begin
        tests_failed++;
        $display("FAIL uart_len%0d_frame: value %h ok %b errs %0d done_cnt %0d", len, v, ok,
                 frame_errs(), done_cnt);
      end
      tests_run++;
      if (viol !== 0) begin
        tests_failed++; $display("FAIL uart_len%0d_protocol: %0d violations want 0", len, viol);
      end
      if (len >= 20) begin
        tests_run++;
        if (bad_gaps(len + 3) !== 0) begin
          tests_failed++; $display("FAIL uart_len%0d_spacing: %0d gaps not %0d", len, bad_gaps(len+3), len+3);
        end
      end
    end
    uart_en = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int acc, dummy;
    bit ok;
    logic [31:0] v1;
    v1 = $urandom();
    clear_mon();
    model_frame(v1);
    pulse_start(v1, acc);
    repeat (5) @(negedge clk);
    pulse_start(~v1, dummy);
    repeat (7) @(negedge clk);
    pulse_start(v1 ^ 32'h5A5A5A5A, dummy);
    wait_done(200, ok);
    repeat (20) @(negedge clk);
    tests_run++;
    if (!ok || frame_errs() !== 0) begin
      tests_failed++; $display("FAIL start_while_busy_frame: ok %b errs %0d", ok, frame_errs());
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++; $display("FAIL start_while_busy_done: got %0d pulses want 1", done_cnt);
    end
  endtask

  task automatic test_start_on_done();
    int acc;
    bit ok;
    logic [31:0] v;
    v = $urandom();
    clear_mon();
    model_frame(v);
    pulse_start(v, acc);
    wait_done(200, ok);
    value = ~v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    tests_run++;
    if (!ok || rx_q.size() !== FrameLen) begin
      tests_failed++; $display("FAIL start_on_done_ignored: ok %b got %0d bytes want %0d", ok, rx_q.size(), FrameLen);
    end
    tests_run++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      tests_failed++; $display("FAIL start_on_done_idle: busy %b done_cnt %0d want 0 and 1", busy, done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc, n;
    bit seen;
    clear_mon();
    pulse_start($urandom(), acc);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (new_tx_data) n++;
      if (n == 4) seen = 1'b1;
      else @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (!seen || new_tx_data !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_frame_outputs: seen %b new %b busy %b want 1 0 0", seen, new_tx_data, busy);
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    tests_run++;
    if (done_cnt !== 0 || rx_q.size() !== 4) begin
      tests_failed++;
      $display("FAIL reset_mid_frame_abort: done_cnt %0d bytes %0d want 0 and 4", done_cnt, rx_q.size());
    end
    test_fixed_frame($urandom());
  endtask

  initial begin
    test_reset();
    test_fixed_frame(32'h91230001);
    test_fixed_frame(32'h1834ABCD);
    test_fixed_frame(32'h00000000);
    test_fixed_frame(32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) test_fixed_frame($urandom());
    test_uart_model(20, 1);
    test_uart_model($urandom_range(0, 6), 3);
    test_start_while_busy();
    test_start_on_done();
    test_fixed_frame($urandom());
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
